// File: rtl/axi_burst_writer.sv
// ADC sample-beat buffer feeding an AXI write-data channel in fixed-length bursts.
// Beats are queued in a small FIFO and released as W-channel bursts of burst_len beats.
module axi_burst_writer #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LEN_WIDTH  = 8
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [LEN_WIDTH-1:0]          burst_len,
    input  logic                          in_valid,
    input  logic [DATA_WIDTH-1:0]         in_data,
    output logic [DATA_WIDTH-1:0]         m_axi_wdata,
    output logic                          m_axi_wvalid,
    input  logic                          m_axi_wready,
    output logic                          m_axi_wlast,
    output logic                          m_axi_wstrb,
    output logic                          overflow,
    input  logic                          overflow_clear,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [0:0] {
        StIdle,
        StSend
    } state_e;

    state_e                 state_q, state_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]   len_m1;
    logic [PtrW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]        level_q, level_d;
    logic                   ovf_q, ovf_d;
    logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic accept;
    logic push;
    logic pop;
    logic drop;
    logic start;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LvlW'(FIFO_DEPTH));

    // A full FIFO can still take a beat when the head leaves on the same edge.
    assign accept = in_valid && enable;
    assign pop    = m_axi_wvalid && m_axi_wready;
    assign push   = accept && (!fifo_full || pop);
    assign drop   = accept && fifo_full && !pop;
    assign start  = (state_q == StIdle) && enable && !fifo_empty;

    // len_q of zero wraps to all ones, giving a 2^LEN_WIDTH beat burst.
    assign len_m1 = len_q - LEN_WIDTH'(1);

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (pop && m_axi_wlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs depend on registered state only
    always_comb begin
        m_axi_wvalid = (state_q == StSend) && !fifo_empty;
        m_axi_wlast  = (state_q == StSend) && (cnt_q == len_m1);
        m_axi_wstrb  = m_axi_wvalid;
        m_axi_wdata  = m_axi_wvalid ? mem_q[rd_ptr_q] : '0;
    end

    always_comb begin
        len_d = len_q;
        cnt_d = cnt_q;
        if (start) begin
            len_d = burst_len;
            cnt_d = '0;
        end else if (pop) begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
        end
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (push && !pop) begin
            level_d = level_q + LvlW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LvlW'(1);
        end
    end

    // A fresh drop wins over a clear on the same edge.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (overflow_clear) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            len_q    <= '0;
            cnt_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign overflow   = ovf_q;
    assign fifo_level = level_q;

endmodule
